// File: rtl/seg_disp_arbiter.sv
// Round-robin owner of the 8-digit display with minimum dwell per grant.
// Define SEG_ARB_LZB_EN to enable registered leading-zero blanking.
module seg_disp_arbiter #(
  parameter int N_REQ       = 3,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*32-1:0] data,
  output logic [N_REQ-1:0]   ack,
  output logic [31:0]        disp_val,
  output logic [7:0]         disp_blank,
  output logic [1:0]         owner,
  output logic               busy
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  owner_q, owner_d;
  logic [31:0] val_q, val_d;
  logic [7:0]  blank_q, blank_d;
  logic        valid_q, valid_d;

  logic        win_found;
  logic [1:0]  win;
  logic [2:0]  idx;
  logic        arb;

`ifdef SEG_ARB_LZB_EN
  function automatic logic [7:0] lzb(input logic [31:0] v);
    logic z;
    lzb = 8'h00;
    z   = 1'b1;
    for (int k = 7; k >= 1; k--) begin
      z      = z & (v[4*k +: 4] == 4'h0);
      lzb[k] = z;
    end
  endfunction
`endif

  // search starts one past the last winner
  always_comb begin
    win_found = 1'b0;
    win       = ptr_q;
    idx       = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = 3'(ptr_q) + 3'(k);
      if (idx >= 3'(N_REQ)) idx = idx - 3'(N_REQ);
      if (!win_found && req[idx[1:0]]) begin
        win_found = 1'b1;
        win       = idx[1:0];
      end
    end
  end

  assign arb = (state_q == IDLE) || (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    val_d   = val_q;
    valid_d = valid_q;
    ack     = '0;
    if (arb) begin
      if (win_found) begin
        ack[win] = 1'b1;
        val_d    = data[32*win +: 32];
        owner_d  = win;
        ptr_d    = win;
        valid_d  = 1'b1;
        cnt_d    = CNT_LOAD;
        state_d  = HOLD;
      end else begin
        state_d = IDLE;
      end
    end else begin
      cnt_d = cnt_q - 1'b1;
      if (req[owner_q]) begin
        ack[owner_q] = 1'b1;
        val_d        = data[32*owner_q +: 32];
      end
    end
    if (clr) ack = '0;
  end

`ifdef SEG_ARB_LZB_EN
  assign blank_d = lzb(val_d);
`else
  assign blank_d = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= 2'(N_REQ - 1);
      owner_q <= '0;
      val_q   <= '0;
      blank_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      val_q   <= val_d;
      blank_q <= blank_d;
      valid_q <= valid_d;
    end
  end

  assign disp_val   = val_q;
  assign disp_blank = valid_q ? blank_q : 8'hFF;
  assign owner      = owner_q;
  assign busy       = (state_q == HOLD);

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Directed bench for seg_disp_arbiter: HOLD_CYCLES=4 and HOLD_CYCLES=1 instances.
// Display values are queued at ack time and compared after the capture edge.
module tb_seg_disp_arbiter;

`ifdef SEG_ARB_LZB_EN
  localparam logic [7:0] BL_ZERO = 8'hFE;
  localparam logic [7:0] BL_1A30 = 8'hF0;
`else
  localparam logic [7:0] BL_ZERO = 8'h00;
  localparam logic [7:0] BL_1A30 = 8'h00;
`endif

  logic        clk;
  logic        clr, clr_b;
  logic [2:0]  req, req_b;
  logic [95:0] data, data_b;
  logic [2:0]  ack, ack_b;
  logic [31:0] disp_val, disp_val_b;
  logic [7:0]  disp_blank, disp_blank_b;
  logic [1:0]  owner, owner_b;
  logic        busy, busy_b;

  int npass = 0;
  int ntot  = 0;
  logic [31:0] sb[$];

  seg_disp_arbiter #(.N_REQ(3), .HOLD_CYCLES(4)) u_dut (
    .clk(clk), .clr(clr), .req(req), .data(data), .ack(ack),
    .disp_val(disp_val), .disp_blank(disp_blank),
    .owner(owner), .busy(busy)
  );

  seg_disp_arbiter #(.N_REQ(3), .HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .clr(clr_b), .req(req_b), .data(data_b), .ack(ack_b),
    .disp_val(disp_val_b), .disp_blank(disp_blank_b),
    .owner(owner_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ntot++;
    assert (obs === exp) begin
      npass++;
    end else begin
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pop_sb();
    logic [31:0] v;
    if (sb.size() == 0) return 32'hDEAD_BEEF;
    v = sb.pop_front();
    return v;
  endfunction

  initial begin
    int drop[3];
    int gi;
    int gcyc[4];
    int gown[4];
    int last;
    logic got;
    logic [2:0] ackd;

    clr = 1'b1; req = '0; data = '0;
    clr_b = 1'b1; req_b = '0; data_b = '0;
    tick; tick;

    // reset values, ack suppressed while clr is high
    req = 3'b001;
    #1;
    chk("rst_ack", ack, 3'b000);
    chk("rst_val", disp_val, 32'h0);
    chk("rst_blank", disp_blank, 8'hFF);
    chk("rst_owner", owner, 2'd0);
    chk("rst_busy", busy, 1'b0);
    req = '0;
    tick;

    // first grant from IDLE
    clr = 1'b0;
    req = 3'b001;
    data[31:0] = 32'h1234_5678;
    #1;
    chk("g0_ack", ack, 3'b001);
    if (ack[0]) sb.push_back(data[31:0]);
    tick;
    req = '0;
    chk("g0_val", disp_val, pop_sb());
    chk("g0_owner", owner, 2'd0);
    chk("g0_busy", busy, 1'b1);
    chk("g0_blank", disp_blank, 8'h00);

    // round robin with all requesters active
    clr = 1'b1; tick; clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data[32*i +: 32] = 32'hC0DE_0000 + i;
      drop[i] = 0;
    end
    gi = 0; last = -1;
    for (int c = 0; c < 14; c++) begin
      for (int i = 0; i < 3; i++) req[i] = (drop[i] == 0);
      #1;
      chk("rr_onehot", 64'($countones(ack) <= 1), 64'd1);
      got = 1'b0;
      ackd = ack;
      for (int i = 0; i < 3; i++) begin
        if (ackd[i]) begin
          sb.push_back(data[32*i +: 32]);
          if (i != last && gi < 4) begin
            gcyc[gi] = c; gown[gi] = i; gi++;
          end
          last = i;
          got = 1'b1;
        end
      end
      tick;
      if (got) chk("rr_val", disp_val, pop_sb());
      for (int i = 0; i < 3; i++) begin
        if (drop[i] > 0) drop[i]--;
        if (ackd[i]) drop[i] = 1;
      end
    end
    chk("rr_count", gi, 4);
    for (int k = 0; k < 4; k++) begin
      chk("rr_order", gown[k], (k == 3) ? 0 : k);
      chk("rr_cycle", gcyc[k], 4 * k);
    end
    req = '0;
    repeat (5) tick;

    // refresh by owner mid-dwell, waiting requester served at expiry
    clr = 1'b1; tick; clr = 1'b0;
    req = 3'b010;
    data[63:32] = 32'h1111_1111;
    #1;
    chk("rf_g1_ack", ack, 3'b010);
    if (ack[1]) sb.push_back(data[63:32]);
    tick;
    chk("rf_g1_val", disp_val, pop_sb());
    chk("rf_g1_owner", owner, 2'd1);
    req = 3'b100;
    data[95:64] = 32'h2222_2222;
    #1;
    chk("rf_wait1", ack, 3'b000);
    tick;
    req = 3'b110;
    data[63:32] = 32'h0000_00AB;
    #1;
    chk("rf_ack", ack, 3'b010);
    if (ack[1]) sb.push_back(data[63:32]);
    tick;
    chk("rf_val", disp_val, pop_sb());
    chk("rf_busy", busy, 1'b1);
    req = 3'b100;
    #1;
    chk("rf_wait2", ack, 3'b000);
    tick;
    #1;
    chk("rf_g2_ack", ack, 3'b100);
    if (ack[2]) sb.push_back(data[95:64]);
    tick;
    chk("rf_g2_val", disp_val, pop_sb());
    chk("rf_g2_owner", owner, 2'd2);

    // clr in the middle of HOLD
    req = 3'b010;
    clr = 1'b1;
    #1;
    chk("cl_ack", ack, 3'b000);
    tick;
    chk("cl_val", disp_val, 32'h0);
    chk("cl_owner", owner, 2'd0);
    chk("cl_busy", busy, 1'b0);
    chk("cl_blank", disp_blank, 8'hFF);
    clr = 1'b0;
    #1;
    chk("cl_reack", ack, 3'b010);
    if (ack[1]) sb.push_back(data[63:32]);
    tick;
    req = '0;
    chk("cl_val2", disp_val, pop_sb());
    chk("cl_owner2", owner, 2'd1);
    chk("cl_busy2", busy, 1'b1);

    // HOLD_CYCLES=1 instance: one-cycle dwell and blank mask
    clr_b = 1'b0;
    req_b = 3'b001;
    data_b[31:0] = 32'h0000_0000;
    #1;
    chk("h1_ack0", ack_b, 3'b001);
    if (ack_b[0]) sb.push_back(data_b[31:0]);
    tick;
    req_b = '0;
    chk("h1_val0", disp_val_b, pop_sb());
    chk("h1_busy0", busy_b, 1'b1);
    chk("h1_blank0", disp_blank_b, BL_ZERO);
    tick;
    chk("h1_idle0", busy_b, 1'b0);
    chk("h1_keep0", disp_val_b, 32'h0);
    chk("h1_kblank0", disp_blank_b, BL_ZERO);
    tick;
    req_b = 3'b001;
    data_b[31:0] = 32'h0000_1A30;
    #1;
    chk("h1_ack1", ack_b, 3'b001);
    if (ack_b[0]) sb.push_back(data_b[31:0]);
    tick;
    req_b = '0;
    chk("h1_val1", disp_val_b, pop_sb());
    chk("h1_busy1", busy_b, 1'b1);
    chk("h1_blank1", disp_blank_b, BL_1A30);
    tick;
    chk("h1_idle1", busy_b, 1'b0);
    chk("h1_keep1", disp_val_b, 32'h0000_1A30);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
